// File: rtl/sprite_pkg.sv
// Shared definitions for the Link sprite fetch pipeline.
// Holds the facing-direction type, sprite geometry, the see-through palette
// index and the sprite ROM address width.
package sprite_pkg;

    typedef enum logic [1:0] {
        DOWN  = 2'd0,
        UP    = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    localparam int          SPRITE_W        = 16;    // sprite edge in pixels, power of two
    localparam int          ANIM_PERIOD     = 8;     // frames per walk phase
    localparam int          COORD_W         = 10;    // screen coordinate width
    localparam int          PIX_W           = 4;     // palette index width
    localparam int          ROM_AW          = 11;    // {dir, frame, dy, dx}
    localparam logic [3:0]  TRANSPARENT_IDX = 4'd0;  // see-through palette index

endpackage

// File: rtl/sprite_anim_ctr.sv
// Walk-animation phase counter.
// Counts frame_start pulses while the sprite is moving; every ANIM_PERIOD
// pulses the walk frame flips. Standing still snaps back to frame 0.
// Ports:
//   Clk, Reset_n  clock / asynchronous active-low reset
//   frame_start   one-cycle pulse per video frame
//   moving        sprite is walking (sampled on frame_start only)
//   anim_frame    current walk frame
module sprite_anim_ctr #(
    parameter int ANIM_PERIOD = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_start,
    input  logic moving,
    output logic anim_frame
);

    localparam int              CNT_W    = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_PERIOD - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_frame;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt   <= '0;
            r_frame <= 1'b0;
        end else if (frame_start) begin
            if (moving) begin
                if (r_cnt == CNT_LAST) begin
                    r_cnt   <= '0;
                    r_frame <= ~r_frame;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt   <= '0;
                r_frame <= 1'b0;
            end
        end
    end

    assign anim_frame = r_frame;

endmodule

// File: rtl/link_sprite_fetch.sv
// Link sprite fetch: per-pixel hit test against the sprite box, sprite ROM
// address generation and transparency resolution.
// Pipeline: stage 0 hit test -> registered rom_addr (ROM reads in the next
// cycle) -> rom_q combined with the twice-delayed hit. Output latency is
// two cycles, one pixel per cycle, never stalls.
// Ports:
//   Clk, Reset_n          clock / asynchronous active-low reset
//   frame_start           start of vertical blank, loads shadow position/dir
//   pix_valid, DrawX/Y    current pixel
//   LinkX/Y, dir, moving  sprite position, facing, walking flag
//   rom_addr / rom_q      external sprite ROM (data one cycle after address)
//   pal_index, sprite_on  palette index and opaque-pixel flag
//   out_valid             pal_index/sprite_on valid
//   anim_frame            current walk frame
module link_sprite_fetch
    import sprite_pkg::*;
#(
    parameter int         SPRITE_W        = sprite_pkg::SPRITE_W,
    parameter int         ANIM_PERIOD     = sprite_pkg::ANIM_PERIOD,
    parameter logic [3:0] TRANSPARENT_IDX = sprite_pkg::TRANSPARENT_IDX
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        LinkX,
    input  logic [9:0]        LinkY,
    input  logic [1:0]        dir,
    input  logic              moving,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    output logic [3:0]        pal_index,
    output logic              sprite_on,
    output logic              out_valid,
    output logic              anim_frame
);

    localparam int                 SW_BITS = $clog2(SPRITE_W);
    localparam logic [COORD_W:0]   SPAN    = (COORD_W + 1)'(SPRITE_W);

    // Shadow copies, stable for a whole frame
    logic [COORD_W-1:0] r_link_x;
    logic [COORD_W-1:0] r_link_y;
    dir_t               r_dir_s;

    logic [COORD_W:0]   w_diff_x;
    logic [COORD_W:0]   w_diff_y;
    logic               w_hit;
    logic [ROM_AW-1:0]  w_rom_addr_next;
    logic               w_anim_frame;

    logic [ROM_AW-1:0]  r_rom_addr;
    logic               r_hit_d1;
    logic               r_vld_d1;
    logic               r_hit_d2;
    logic               r_vld_d2;
    logic               w_show;

    sprite_anim_ctr #(
        .ANIM_PERIOD (ANIM_PERIOD)
    ) u_anim (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .moving      (moving),
        .anim_frame  (w_anim_frame)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_link_x <= '0;
            r_link_y <= '0;
            r_dir_s  <= DOWN;
        end else if (frame_start) begin
            r_link_x <= LinkX;
            r_link_y <= LinkY;
            r_dir_s  <= dir_t'(dir);
        end
    end

    // The extra MSB of each difference is the borrow: a pixel left of / above
    // the sprite origin yields a value >= 1024 and fails the range test, so a
    // sprite near the far screen edge is clipped rather than wrapped to 0.
    // The low 10 bits are the modulo-2^10 dx/dy used for addressing.
    assign w_diff_x = {1'b0, DrawX} - {1'b0, r_link_x};
    assign w_diff_y = {1'b0, DrawY} - {1'b0, r_link_y};
    assign w_hit    = pix_valid & (w_diff_x < SPAN) & (w_diff_y < SPAN);

    assign w_rom_addr_next = {r_dir_s, w_anim_frame,
                              w_diff_y[SW_BITS-1:0], w_diff_x[SW_BITS-1:0]};

    // Stage 1: address register (held while idle) and delayed hit/valid
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rom_addr <= '0;
            r_hit_d1   <= 1'b0;
            r_vld_d1   <= 1'b0;
            r_hit_d2   <= 1'b0;
            r_vld_d2   <= 1'b0;
        end else begin
            if (pix_valid) begin
                r_rom_addr <= w_rom_addr_next;
            end
            r_hit_d1 <= w_hit;
            r_vld_d1 <= pix_valid;
            r_hit_d2 <= r_hit_d1;
            r_vld_d2 <= r_vld_d1;
        end
    end

    // Stage 2: rom_q arrives aligned with the twice-delayed hit
    assign w_show     = r_vld_d2 & r_hit_d2;
    assign pal_index  = w_show ? rom_q : TRANSPARENT_IDX;
    assign sprite_on  = w_show & (rom_q != TRANSPARENT_IDX);
    assign out_valid  = r_vld_d2;
    assign rom_addr   = r_rom_addr;
    assign anim_frame = w_anim_frame;

endmodule

// File: tb/tb_link_sprite_fetch.sv
module tb_link_sprite_fetch;
    import sprite_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_start, pix_valid, moving;
    logic [9:0]  DrawX, DrawY, LinkX, LinkY;
    logic [1:0]  dir;
    logic [10:0] rom_addr;
    logic [3:0]  rom_q;
    logic [3:0]  pal_index;
    logic        sprite_on, out_valid, anim_frame;

    link_sprite_fetch dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .LinkX(LinkX), .LinkY(LinkY), .dir(dir), .moving(moving),
        .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
        .sprite_on(sprite_on), .out_valid(out_valid), .anim_frame(anim_frame)
    );

    always #5 Clk = ~Clk;

    // External sprite ROM: synchronous read
    logic [3:0] rom_mem [2048];
    always @(posedge Clk) rom_q <= rom_mem[rom_addr];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit vld;
        bit hit;
        int addr;
        int pal;
        bit on;
    } pix_t;

    int   m_lx, m_ly, m_dir, m_moves, m_last_addr;
    pix_t p1, p2;

    // Walk frame: number of complete ANIM_PERIOD-long runs of moving frames, parity
    function automatic int m_frame();
        return (m_moves / 8) % 2;
    endfunction

    function automatic int wrap1024(input int v);
        return ((v % 1024) + 1024) % 1024;
    endfunction

    function automatic pix_t model_pixel(input bit pv, input int x, input int y);
        pix_t r;
        int dx, dy;
        dx     = x - m_lx;
        dy     = y - m_ly;
        r.vld  = pv;
        r.hit  = pv && dx >= 0 && dx < 16 && dy >= 0 && dy < 16;
        r.addr = m_dir * 512 + m_frame() * 256 + (wrap1024(dy) % 16) * 16 + (wrap1024(dx) % 16);
        r.pal  = r.hit ? int'(rom_mem[r.addr]) : 0;
        r.on   = r.hit && r.pal != 0;
        return r;
    endfunction

    // Observed outputs at the start of the most recent step
    int obs_valid, obs_pal, obs_on, obs_addr, obs_frame;
    int cur_lx, cur_ly, cur_dir;
    bit cur_mov;

    // One clock: check outputs against model, then drive the new inputs
    task automatic step(input bit fs, input bit pv, input int x, input int y,
                        input int lx, input int ly, input int d, input bit mov);
        pix_t np;
        @(negedge Clk);
        obs_valid = out_valid;
        obs_pal   = pal_index;
        obs_on    = sprite_on;
        obs_addr  = rom_addr;
        obs_frame = anim_frame;
        check("out_valid", out_valid, p2.vld);
        check("sprite_on", sprite_on, p2.on);
        if (p2.vld) check("pal_index", pal_index, p2.pal);
        check("rom_addr", rom_addr, m_last_addr);
        check("anim_frame", anim_frame, m_frame());
        frame_start = fs;
        pix_valid   = pv;
        DrawX       = 10'(wrap1024(x));
        DrawY       = 10'(wrap1024(y));
        LinkX       = 10'(lx);
        LinkY       = 10'(ly);
        dir         = 2'(d);
        moving      = mov;
        cur_lx = lx; cur_ly = ly; cur_dir = d; cur_mov = mov;
        np = model_pixel(pv, wrap1024(x), wrap1024(y));
        if (pv) m_last_addr = np.addr;
        p2 = p1;
        p1 = np;
        if (fs) begin
            m_lx  = lx;
            m_ly  = ly;
            m_dir = d;
            if (mov) m_moves++;
            else     m_moves = 0;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 0, cur_lx, cur_ly, cur_dir, cur_mov);
    endtask

    task automatic pixel(input int x, input int y);
        step(1'b0, 1'b1, x, y, cur_lx, cur_ly, cur_dir, cur_mov);
    endtask

    task automatic new_frame(input int lx, input int ly, input int d, input bit mov);
        step(1'b1, 1'b0, 0, 0, lx, ly, d, mov);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n     = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sprite_on", sprite_on, 0);
        check("rst_pal_index", pal_index, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_anim_frame", anim_frame, 0);
        p1 = '{default: 0};
        p2 = '{default: 0};
        m_last_addr = 0;
        m_lx = 0; m_ly = 0; m_dir = 0; m_moves = 0;
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int x;
        int y;
        int addr;
        int pal;
        bit on;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Link=(100,50), RIGHT, frame 0
        vecs[0] = '{x: 103, y: 52, addr: 'h623, pal: 5, on: 1};
        vecs[1] = '{x:  99, y: 52, addr: 'h62F, pal: 0, on: 0};
        vecs[2] = '{x: 104, y: 52, addr: 'h624, pal: 0, on: 0};
        vecs[3] = '{x: 115, y: 65, addr: 'h6FF, pal: 9, on: 1};
        vecs[4] = '{x: 116, y: 50, addr: 'h600, pal: 0, on: 0};
        vecs[5] = '{x: 100, y: 66, addr: 'h600, pal: 0, on: 0};
        vecs[6] = '{x: 100, y: 50, addr: 'h600, pal: 7, on: 1};

        for (int i = 0; i < 2048; i++) rom_mem[i] = 4'($urandom_range(0, 15));
        rom_mem['h623] = 4'd5;
        rom_mem['h624] = 4'd0;
        rom_mem['h6FF] = 4'd9;
        rom_mem['h600] = 4'd7;
        rom_mem['h622] = 4'd11;

        Reset_n = 1'b0; frame_start = 0; pix_valid = 0; moving = 0;
        DrawX = 0; DrawY = 0; LinkX = 0; LinkY = 0; dir = 0;
        cur_lx = 0; cur_ly = 0; cur_dir = 0; cur_mov = 0;
        do_reset();

        // Table: isolated pixels with hand-derived expectations
        new_frame(100, 50, 3, 1'b0);
        for (int i = 0; i < 7; i++) begin
            pixel(vecs[i].x, vecs[i].y);
            idle();
            check("tbl_addr", obs_addr, vecs[i].addr);
            idle();
            check("tbl_valid", obs_valid, 1);
            check("tbl_pal", obs_pal, vecs[i].pal);
            check("tbl_on", obs_on, int'(vecs[i].on));
        end
        // Same table back-to-back, one pixel per cycle
        for (int i = 0; i < 7; i++) pixel(vecs[i].x, vecs[i].y);
        idle(); idle();

        // Walk animation across 16 frame_starts
        for (int i = 1; i <= 16; i++) begin
            new_frame(100, 50, 3, 1'b1);
            idle();
            check("anim_pulse", obs_frame, (i >= 8 && i < 16) ? 1 : 0);
            if (i == 8) begin
                pixel(103, 52);
                idle();
                check("anim_addr", obs_addr, 'h723);
            end
        end
        new_frame(100, 50, 3, 1'b0);
        idle();
        check("anim_stop", obs_frame, 0);

        // LinkX changes mid-frame: shadow keeps 100
        cur_lx = 200;
        pixel(103, 52); idle(); idle();
        check("shadow_hold_on", obs_on, 1);
        check("shadow_hold_pal", obs_pal, 5);
        // frame_start in the same cycle as a pixel: pixel uses old LinkX
        step(1'b1, 1'b1, 103, 52, 200, 50, 3, 1'b0);
        idle(); idle();
        check("same_cycle_on", obs_on, 1);
        check("same_cycle_pal", obs_pal, 5);
        pixel(203, 52); idle(); idle();
        check("new_link_on", obs_on, 1);
        pixel(103, 52); idle(); idle();
        check("old_pos_valid", obs_valid, 1);
        check("old_pos_on", obs_on, 0);

        // Right-edge clipping
        new_frame(1020, 50, 3, 1'b0);
        pixel(2, 52); idle(); idle();
        check("edge_nohit_valid", obs_valid, 1);
        check("edge_nohit_on", obs_on, 0);
        check("edge_nohit_pal", obs_pal, 0);
        pixel(1022, 52); idle();
        check("edge_hit_addr", obs_addr, 'h622);
        idle();
        check("edge_hit_on", obs_on, 1);
        check("edge_hit_pal", obs_pal, 11);

        // Reset with two pixels in flight
        new_frame(100, 50, 3, 1'b0);
        pixel(103, 52);
        pixel(115, 65);
        do_reset();
        idle(); idle(); idle();
        check("post_rst_quiet", obs_valid, 0);
        new_frame(100, 50, 3, 1'b0);
        pixel(103, 52); idle(); idle();
        check("post_rst_on", obs_on, 1);
        check("post_rst_pal", obs_pal, 5);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bit fs, pv;
            int lx, ly, x, y;
            fs = ($urandom_range(0, 11) == 0);
            pv = ($urandom_range(0, 3) != 0);
            lx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1005, 1023)) : int'($urandom_range(0, 1023));
            ly = int'($urandom_range(0, 1023));
            x  = m_lx + int'($urandom_range(0, 24)) - 4;
            y  = m_ly + int'($urandom_range(0, 24)) - 4;
            step(fs, pv, x, y, lx, ly, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) != 0));
        end
        idle(); idle(); idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
